game_tick_scheduler: RTL

GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

---
 rtl/game_tick_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: paces snake updates from a score-dependent period,
// with pause toggling, an update request handshake and overrun detection.
module game_tick_scheduler #(
  parameter int BASE_PERIOD  = 4166667,
  parameter int STEP         = 250000,
  parameter int MIN_PERIOD   = 1000000,
  parameter int PERIOD_WIDTH = 23
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] MASTER_STATE,
  input  logic [3:0] SCORE,
  input  logic       PAUSE_BTN,
  input  logic       UPDATE_DONE,
  output logic       GAMECLOCK,
  output logic       UPDATE_REQ,
  output logic [2:0] SPEED_LEVEL,
  output logic       PAUSED,
  output logic       OVERRUN
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSE  = 2'b10
  } state_t;

  localparam logic [31:0] BASE_U = 32'(BASE_PERIOD);
  localparam logic [31:0] STEP_U = 32'(STEP);
  localparam logic [31:0] DIFF_U = 32'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] BASE_P = PERIOD_WIDTH'(BASE_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P  = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE    = PERIOD_WIDTH'(1);

  state_t                  state, state_n;
  logic [PERIOD_WIDTH-1:0] count, count_n;
  logic [PERIOD_WIDTH-1:0] period, period_n;
  logic [PERIOD_WIDTH-1:0] period_calc;
  logic [31:0]             prod;
  logic                    tick, tick_n;
  logic                    req, req_n;
  logic                    ovr, ovr_n;
  logic [2:0]              speed, speed_n;
  logic                    pause_prev;
  logic                    pause_rise;
  logic                    at_last;
  logic                    playing;

  // Score-scaled period, clamped to the floor before it could underflow
  always_comb begin
    prod        = {28'd0, SCORE} * STEP_U;
    period_calc = (prod >= DIFF_U) ? MIN_P : PERIOD_WIDTH'(BASE_U - prod);
  end

  assign pause_rise = PAUSE_BTN & ~pause_prev;
  assign at_last    = (count == period - ONE);
  assign playing    = (MASTER_STATE == 2'b01);
  assign speed_n    = (SCORE > 4'd7) ? 3'd7 : SCORE[2:0];

  // Next state, counter, period latch and handshake outputs
  always_comb begin
    state_n  = state;
    count_n  = count;
    period_n = period;
    tick_n   = 1'b0;
    req_n    = req;
    ovr_n    = ovr;
    if (req && UPDATE_DONE) req_n = 1'b0;
    unique case (state)
      IDLE: begin
        count_n = '0;
        req_n   = 1'b0;
        if (playing) begin
          state_n  = RUN;
          period_n = period_calc;
          ovr_n    = 1'b0;
        end
      end
      RUN: begin
        if (pause_rise) begin
          state_n = PAUSE;
        end else if (at_last) begin
          count_n  = '0;
          period_n = period_calc;
          if (req && !UPDATE_DONE) begin
            ovr_n = 1'b1;
          end else begin
            tick_n = 1'b1;
            req_n  = 1'b1;
          end
        end else begin
          count_n = count + ONE;
        end
      end
      PAUSE: begin
        if (pause_rise) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
    if (!playing) begin
      state_n = IDLE;
      count_n = '0;
      req_n   = 1'b0;
      tick_n  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      count      <= '0;
      period     <= BASE_P;
      tick       <= 1'b0;
      req        <= 1'b0;
      ovr        <= 1'b0;
      speed      <= 3'd0;
      pause_prev <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      period     <= period_n;
      tick       <= tick_n;
      req        <= req_n;
      ovr        <= ovr_n;
      speed      <= speed_n;
      pause_prev <= PAUSE_BTN;
    end
  end

  assign GAMECLOCK   = tick;
  assign UPDATE_REQ  = req;
  assign OVERRUN     = ovr;
  assign SPEED_LEVEL = speed;
  assign PAUSED      = (state == PAUSE);

endmodule
